// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command controller.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_DHI,
    S_DLO,
    S_CHK,
    S_EXEC
  } state_t;

  localparam logic [7:0] SYNC = 8'hA5;

  localparam logic [1:0] OP_WR  = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_CLR = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  localparam int NREGS = 4;

endpackage

// File: rtl/uart_cmd_timeout.sv
// Inter-byte timeout: counts idle cycles while enabled, pulses
// expire on the cycle the count reaches TO_CYC.
module uart_cmd_timeout #(
  parameter int TO_CYC = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic reload,
  output logic expire
);

  localparam int CW = $clog2(TO_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(TO_CYC - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || !enable || reload) begin
      cnt <= '0;
    end else if (cnt != LAST) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expire = enable && !reload && (cnt == LAST);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Framed UART command decoder driving four 16-bit registers.
// Define UART_CMD_CHECKSUM_EN to enforce CHK == CMD^DHI^DLO.
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int CLK_HZ        = 12_000_000,
  parameter int BIT_RATE      = 9600,
  parameter int TIMEOUT_BYTES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid,
  input  logic [7:0]  data,
  input  logic [1:0]  rd_addr,
  output logic [15:0] rd_data,
  output logic        wr_strobe,
  output logic [1:0]  wr_addr,
  output logic        err,
  output logic [7:0]  err_cnt,
  output logic        busy
);

  localparam int TO_CYC = TIMEOUT_BYTES * 10 * (CLK_HZ / BIT_RATE);

  state_t      state;
  logic [1:0]  op_q;
  logic [1:0]  addr_q;
  logic [7:0]  dhi_q;
  logic [7:0]  dlo_q;
  logic [15:0] regs [NREGS];
  logic        to_en;
  logic        expire;
  logic        cmd_bad;
  logic        chk_ok;
  logic        fail;
  logic [15:0] wval;

`ifdef UART_CMD_CHECKSUM_EN
  logic [7:0] sum_q;
  assign chk_ok = (data == sum_q);
`else
  assign chk_ok = 1'b1;
`endif

  assign rd_data = regs[rd_addr];
  assign to_en   = (state == S_CMD) || (state == S_DHI) ||
                   (state == S_DLO) || (state == S_CHK);
  assign cmd_bad = (data[7:6] == OP_RSV) || (|data[5:2]);

  uart_cmd_timeout #(
    .TO_CYC (TO_CYC)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (to_en),
    .reload (valid),
    .expire (expire)
  );

  // A byte on the expiry cycle wins over the timeout.
  always_comb begin
    fail = 1'b0;
    if (to_en) begin
      if (valid) begin
        fail = ((state == S_CMD) && cmd_bad) ||
               ((state == S_CHK) && !chk_ok);
      end else begin
        fail = expire;
      end
    end
  end

  always_comb begin
    wval = 16'h0000;
    unique case (1'b1)
      (op_q == OP_WR):  wval = {dhi_q, dlo_q};
      (op_q == OP_ADD): wval = regs[addr_q] + {dhi_q, dlo_q};
      default:          wval = 16'h0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= 2'd0;
      err       <= 1'b0;
      err_cnt   <= 8'd0;
      op_q      <= OP_WR;
      addr_q    <= 2'd0;
      dhi_q     <= 8'd0;
      dlo_q     <= 8'd0;
`ifdef UART_CMD_CHECKSUM_EN
      sum_q     <= 8'd0;
`endif
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= 16'h0000;
      end
    end else begin
      wr_strobe <= 1'b0;
      err       <= 1'b0;
      if (fail) begin
        state <= S_IDLE;
        busy  <= 1'b0;
        err   <= 1'b1;
        if (err_cnt != 8'hFF) begin
          err_cnt <= err_cnt + 8'd1;
        end
      end else if (valid) begin
        unique case (state)
          S_IDLE, S_EXEC: begin
            if (data == SYNC) begin
              state <= S_CMD;
              busy  <= 1'b1;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end
          S_CMD: begin
            op_q   <= data[7:6];
            addr_q <= data[1:0];
`ifdef UART_CMD_CHECKSUM_EN
            sum_q  <= data;
`endif
            state  <= S_DHI;
          end
          S_DHI: begin
            dhi_q <= data;
`ifdef UART_CMD_CHECKSUM_EN
            sum_q <= sum_q ^ data;
`endif
            state <= S_DLO;
          end
          S_DLO: begin
            dlo_q <= data;
`ifdef UART_CMD_CHECKSUM_EN
            sum_q <= sum_q ^ data;
`endif
            state <= S_CHK;
          end
          S_CHK: begin
            regs[addr_q] <= wval;
            wr_strobe    <= 1'b1;
            wr_addr      <= addr_q;
            state        <= S_EXEC;
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end else if (state == S_EXEC) begin
        state <= S_IDLE;
        busy  <= 1'b0;
      end
    end
  end

endmodule
